// File: rtl/core_fm_pkg.sv
// Shared Q-format constants and helpers for the feature-map cores.
// Provides the accumulator width rule and the shift/saturate step.
package core_fm_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int FRAC_DEF   = 16;
    localparam int MAXW       = 128;

    // Width that holds the sum of ch full-precision products.
    function automatic int sum_width(input int dw, input int ch);
        return 2 * dw + $clog2(ch);
    endfunction

    // Floor-shift by frac, then clamp to the signed dw-bit range.
    function automatic logic signed [MAXW-1:0] sat_shift(
        input logic signed [MAXW-1:0] x,
        input int frac,
        input int dw
    );
        logic signed [MAXW-1:0] s;
        logic signed [MAXW-1:0] one;
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        one = {{(MAXW-1){1'b0}}, 1'b1};
        s   = x >>> frac;
        hi  = (one <<< (dw - 1)) - one;
        lo  = -(one <<< (dw - 1));
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/fm_obuf_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// Head entry is visible on rdata_o whenever empty_o is low.
module fm_obuf_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next pointer and occupancy values.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = wr_q + PW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/core_featuremap_pointwise_conv.sv
// Pointwise (1x1) convolution over CH lockstep input channels.
// Credit-based issue into a 3-stage MAC pipe feeding an output buffer.
module core_featuremap_pointwise_conv
    import core_fm_pkg::*;
#(
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int FRAC       = FRAC_DEF,
    parameter int CH         = 8,
    parameter int OBUF_DEPTH = 8,
    parameter int FM_PIXELS  = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CH*DWIDTH-1:0]          ff_rdata,
    input  logic [CH-1:0]                 ff_empty,
    output logic                          ff_rdreq,
    output logic [DWIDTH-1:0]             ff_wdata,
    output logic                          ff_wrreq,
    input  logic                          ff_full,
    input  logic                          cfg_we,
    input  logic [$clog2(CH+1)-1:0]       cfg_addr,
    input  logic [DWIDTH-1:0]             cfg_wdata,
    input  logic                          cfg_relu,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FM_PIXELS)-1:0]  pix_cnt
);

    localparam int PRW = 2 * DWIDTH;
    localparam int SW  = sum_width(DWIDTH, CH);
    localparam int AW  = SW + 1;
    localparam int CAW = $clog2(CH + 1);
    localparam int CW  = $clog2(OBUF_DEPTH) + 1;
    localparam int PCW = $clog2(FM_PIXELS);

    logic [DWIDTH-1:0]        wts_q [CH];
    logic [DWIDTH-1:0]        bias_q;
    logic                     rd_q;
    logic                     v1_q;
    logic                     v2_q;
    logic signed [PRW-1:0]    prod_q [CH];
    logic signed [PRW-1:0]    prod_d [CH];
    logic signed [SW-1:0]     sum_q;
    logic signed [SW-1:0]     sum_d;
    logic signed [AW-1:0]     acc;
    logic [DWIDTH-1:0]        res;
    logic [1:0]               inflight;
    logic [CW-1:0]            obuf_cnt;
    logic [CW:0]              used;
    logic [DWIDTH-1:0]        obuf_head;
    logic                     obuf_empty;
    logic                     obuf_full;
    logic                     credit_ok;
    logic                     cfg_ok;
    logic [PCW-1:0]           pix_q, pix_d;
    logic                     pix_last;

    assign inflight  = {1'b0, rd_q} + {1'b0, v1_q} + {1'b0, v2_q};
    assign used      = (CW+1)'(inflight) + {1'b0, obuf_cnt};
    assign credit_ok = ~obuf_full & (used < (CW+1)'(OBUF_DEPTH));
    assign ff_rdreq  = ~reset & ~|ff_empty & credit_ok;
    assign ff_wrreq  = ~reset & ~obuf_empty & ~ff_full;
    assign ff_wdata  = obuf_empty ? '0 : obuf_head;
    assign busy      = (inflight != 2'd0) | ~obuf_empty;
    assign cfg_ok    = cfg_we & ~busy & ~ff_rdreq;
    assign pix_last  = (pix_q == PCW'(FM_PIXELS - 1));
    assign frame_done = ff_wrreq & pix_last;
    assign pix_cnt   = pix_q;

    // Stage 1 products: sample times weight at full precision.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            prod_d[c] = PRW'($signed(ff_rdata[c*DWIDTH +: DWIDTH]))
                      * PRW'($signed(wts_q[c]));
        end
    end

    // Stage 2 reduction across channels.
    always_comb begin
        sum_d = '0;
        for (int c = 0; c < CH; c++) begin
            sum_d = sum_d + SW'(prod_q[c]);
        end
    end

    // Stage 3: bias, rescale, saturate, optional ReLU.
    always_comb begin
        acc = AW'(sum_q) + (AW'($signed(bias_q)) <<< FRAC);
        res = DWIDTH'(sat_shift(MAXW'(acc), FRAC, DWIDTH));
        if (cfg_relu && res[DWIDTH-1]) begin
            res = '0;
        end
    end

    // Stage valid chain; a beat read now carries data next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            rd_q <= ff_rdreq;
            v1_q <= rd_q;
            v2_q <= v1_q;
        end
    end

    // Datapath registers, loaded only by valid beats.
    always_ff @(posedge clock) begin
        if (rd_q) begin
            prod_q <= prod_d;
        end
        if (v1_q) begin
            sum_q <= sum_d;
        end
    end

    // Weight and bias registers, writable only while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                wts_q[c] <= '0;
            end
            bias_q <= '0;
        end else if (cfg_ok) begin
            for (int c = 0; c < CH; c++) begin
                if (cfg_addr == CAW'(c)) begin
                    wts_q[c] <= cfg_wdata;
                end
            end
            if (cfg_addr == CAW'(CH)) begin
                bias_q <= cfg_wdata;
            end
        end
    end

    // Pixel counter wraps at the end of each map.
    always_comb begin
        pix_d = pix_q;
        if (ff_wrreq) begin
            pix_d = pix_last ? '0 : pix_q + PCW'(1);
        end
    end

    // Pixel counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    fm_obuf_fifo #(
        .WIDTH (DWIDTH),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clock   (clock),
        .reset   (reset),
        .push_i  (v2_q),
        .wdata_i (res),
        .pop_i   (ff_wrreq),
        .rdata_o (obuf_head),
        .empty_o (obuf_empty),
        .full_o  (obuf_full),
        .count_o (obuf_cnt)
    );

endmodule

// File: tb/tb_core_featuremap_pointwise_conv.sv
// Randomized bench for the pointwise conv core.
// Input FIFOs and expected outputs are modelled with queues.
module tb_core_featuremap_pointwise_conv;

    localparam int DW  = 32;
    localparam int FR  = 16;
    localparam int CH  = 8;
    localparam int OD  = 8;
    localparam int FMP = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [CH*DW-1:0]  ff_rdata;
    logic [CH-1:0]     ff_empty;
    logic              ff_rdreq;
    logic [DW-1:0]     ff_wdata;
    logic              ff_wrreq;
    logic              ff_full;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic [DW-1:0]     cfg_wdata;
    logic              cfg_relu;
    logic              busy;
    logic              frame_done;
    logic [3:0]        pix_cnt;

    always #5 clock = ~clock;

    core_featuremap_pointwise_conv #(
        .DWIDTH     (DW),
        .FRAC       (FR),
        .CH         (CH),
        .OBUF_DEPTH (OD),
        .FM_PIXELS  (FMP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ff_rdata   (ff_rdata),
        .ff_empty   (ff_empty),
        .ff_rdreq   (ff_rdreq),
        .ff_wdata   (ff_wdata),
        .ff_wrreq   (ff_wrreq),
        .ff_full    (ff_full),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_relu   (cfg_relu),
        .busy       (busy),
        .frame_done (frame_done),
        .pix_cnt    (pix_cnt)
    );

    logic            rst_s, full_s, relu_s, we_s;
    logic [3:0]      addr_s;
    logic [DW-1:0]   wd_s;
    logic [CH-1:0]   hold_s;

    logic [DW-1:0]   mw [CH];
    logic [DW-1:0]   mb;
    logic [CH*DW-1:0] in_q [$];
    logic [CH*DW-1:0] pend;
    bit              have_pend;
    logic [DW-1:0]   exp_q [$];
    int              outst, mpix, cyc, n_rd, n_wr, n_fd, max_out;
    int              last_rd_cyc, last_wr_cyc, first_wr_cyc, wr_mark;
    logic [DW-1:0]   last_wdata;
    int              n_chk, n_err;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_px(input logic [CH*DW-1:0] px);
        logic signed [127:0] acc, a, b, hi, lo;
        hi  = 128'sd2147483647;
        lo  = -128'sd2147483648;
        acc = '0;
        for (int c = 0; c < CH; c++) begin
            a   = $signed(px[c*DW +: DW]);
            b   = $signed(mw[c]);
            acc = acc + a * b;
        end
        a   = $signed(mb);
        acc = acc + a * 65536;
        acc = acc >>> FR;
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
        if (relu_s && acc < 0) acc = '0;
        return acc[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rnd_val();
        logic [DW-1:0] v;
        v = $urandom();
        if ($urandom_range(0, 3) != 0) v = {{12{v[19]}}, v[19:0]};
        return v;
    endfunction

    function automatic logic [CH*DW-1:0] rnd_px();
        logic [CH*DW-1:0] px;
        for (int c = 0; c < CH; c++) px[c*DW +: DW] = rnd_val();
        return px;
    endfunction

    task automatic step();
        bit acc_cfg;
        @(negedge clock);
        reset     = rst_s;
        ff_full   = full_s;
        cfg_relu  = relu_s;
        cfg_we    = we_s;
        cfg_addr  = addr_s;
        cfg_wdata = wd_s;
        we_s      = 1'b0;
        if (have_pend) begin
            ff_rdata = pend;
        end else begin
            for (int c = 0; c < CH; c++) ff_rdata[c*DW +: DW] = $urandom();
        end
        have_pend = 0;
        for (int c = 0; c < CH; c++)
            ff_empty[c] = (in_q.size() == 0) | hold_s[c];
        #1;
        cyc++;
        if (reset) begin
            for (int c = 0; c < CH; c++) mw[c] = '0;
            mb = '0;
            exp_q.delete();
            outst = 0;
            mpix  = 0;
            return;
        end
        acc_cfg = cfg_we && (outst == 0) && (ff_empty != '0);
        if (acc_cfg) begin
            if (cfg_addr < CH) mw[cfg_addr] = cfg_wdata;
            else if (cfg_addr == CH) mb = cfg_wdata;
        end
        if (ff_wrreq) begin
            if (exp_q.size() == 0) begin
                chk("spurious_wr", 64'(ff_wrreq), 64'd0);
            end else begin
                chk("wdata", 64'(ff_wdata), 64'(exp_q.pop_front()));
                outst--;
            end
            chk("frame_done", 64'(frame_done), 64'(mpix == FMP - 1));
            chk("pix_cnt", 64'(pix_cnt), 64'(mpix));
            mpix = (mpix + 1) % FMP;
            if (n_wr == wr_mark) first_wr_cyc = cyc;
            n_wr++;
            if (frame_done) n_fd++;
            last_wr_cyc = cyc;
            last_wdata  = ff_wdata;
        end else begin
            chk("fd_idle", 64'(frame_done), 64'd0);
        end
        if (ff_rdreq) begin
            chk("rd_gate", 64'(ff_empty == '0), 64'd1);
            if (in_q.size() > 0) begin
                pend      = in_q.pop_front();
                have_pend = 1;
                exp_q.push_back(ref_px(pend));
                outst++;
            end
            n_rd++;
            last_rd_cyc = cyc;
        end
        if (outst > max_out) max_out = outst;
    endtask

    task automatic cfg(input int a, input logic [DW-1:0] d);
        addr_s = 4'(a);
        wd_s   = d;
        we_s   = 1'b1;
        step();
    endtask

    task automatic cfg_rand();
        for (int c = 0; c <= CH; c++) cfg(c, rnd_val());
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 600; i++) begin
            if (in_q.size() == 0 && outst == 0) begin
                done = 1;
                break;
            end
            step();
        end
        chk("drain_done", 64'(done), 64'd1);
        step();
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic chk_reset_state();
        chk("rst_rdreq", 64'(ff_rdreq), 64'd0);
        chk("rst_wrreq", 64'(ff_wrreq), 64'd0);
        chk("rst_wdata", 64'(ff_wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fd", 64'(frame_done), 64'd0);
        chk("rst_pix", 64'(pix_cnt), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [CH*DW-1:0] px;
        logic [DW-1:0]    bv;
        int m, w0, f0, k;
        n_chk = 0; n_err = 0; cyc = 0; n_rd = 0; n_wr = 0; n_fd = 0;
        outst = 0; mpix = 0; max_out = 0; wr_mark = 0; have_pend = 0;
        last_rd_cyc = 0; last_wr_cyc = 0; first_wr_cyc = 0;
        last_wdata = '0; mb = '0;
        for (int c = 0; c < CH; c++) mw[c] = '0;
        rst_s = 1; full_s = 0; relu_s = 0; we_s = 0;
        addr_s = '0; wd_s = '0; hold_s = '0;
        reset = 1; ff_full = 0; cfg_relu = 0; cfg_we = 0;
        cfg_addr = '0; cfg_wdata = '0; ff_rdata = '0; ff_empty = '1;

        step(); step();
        rst_s = 0;
        step();
        chk_reset_state();

        for (int c = 0; c < CH; c++) cfg(c, 32'h0001_0000);
        cfg(CH, '0);
        for (int c = 0; c < CH; c++) px[c*DW +: DW] = (c + 1) << 16;
        in_q.push_back(px);
        drain();
        chk("latency", 64'(last_wr_cyc - last_rd_cyc), 64'd4);
        chk("sum36", 64'(last_wdata), 64'h0024_0000);

        cfg_rand();
        hold_s = 8'h08;
        for (int i = 0; i < 8; i++) in_q.push_back(rnd_px());
        m = n_rd;
        repeat (12) step();
        chk("hold_block", 64'(n_rd - m), 64'd0);
        for (int i = 0; i < 24; i++) in_q.push_back(rnd_px());
        wr_mark = n_wr;
        hold_s  = '0;
        drain();
        chk("stream_rate", 64'(last_wr_cyc - first_wr_cyc), 64'd31);

        cfg_rand();
        for (int i = 0; i < 64; i++) in_q.push_back(rnd_px());
        w0 = n_wr;
        repeat (10) step();
        full_s = 1;
        m = n_wr;
        repeat (20) step();
        chk("full_no_wr", 64'(n_wr - m), 64'd0);
        chk("credit_cap", 64'(outst), 64'd8);
        full_s = 0;
        drain();
        chk("no_loss", 64'(n_wr - w0), 64'd64);
        chk("max_out", 64'(max_out <= OD), 64'd1);

        for (int c = 0; c < CH; c++) cfg(c, 32'h7FFF_FFFF);
        cfg(CH, '0);
        for (int c = 0; c < CH; c++) px[c*DW +: DW] = 32'h4000_0000;
        in_q.push_back(px);
        drain();
        chk("sat_pos", 64'(last_wdata), 64'h7FFF_FFFF);

        relu_s = 1;
        for (int c = 0; c < CH; c++) cfg(c, 32'h0001_0000);
        for (int c = 0; c < CH; c++) px[c*DW +: DW] = 32'hFFFF_0000;
        in_q.push_back(px);
        drain();
        chk("relu_neg", 64'(last_wdata), 64'd0);

        relu_s = 0;
        cfg(0, 32'h0001_0000);
        for (int c = 1; c < CH; c++) cfg(c, '0);
        cfg(CH, 32'hFFFF_8000);
        px = rnd_px();
        px[DW-1:0] = 32'h0000_4000;
        in_q.push_back(px);
        drain();
        chk("bias_neg", 64'(last_wdata), 64'hFFFF_C000);

        cfg(0, 32'h0002_0000);
        cfg(CH, '0);
        full_s = 1;
        for (int i = 0; i < 4; i++) begin
            px = rnd_px();
            px[DW-1:0] = 32'h0001_0000;
            in_q.push_back(px);
        end
        for (int i = 0; i < 50; i++) begin
            if (in_q.size() == 0 && outst == 4) break;
            step();
        end
        chk("busy_setup", 64'(outst), 64'd4);
        chk("busy_high", 64'(busy), 64'd1);
        cfg(0, 32'h0005_0000);
        full_s = 0;
        drain();
        px = rnd_px();
        px[DW-1:0] = 32'h0001_0000;
        in_q.push_back(px);
        drain();
        chk("busy_cfg_ign", 64'(last_wdata), 64'h0002_0000);

        cfg_rand();
        k  = 32 - mpix;
        f0 = n_fd;
        for (int i = 0; i < k; i++) in_q.push_back(rnd_px());
        drain();
        chk("fd_count", 64'(n_fd - f0), 64'd2);
        chk("pix_wrap", 64'(pix_cnt), 64'd0);

        cfg_rand();
        for (int i = 0; i < 10; i++) in_q.push_back(rnd_px());
        for (int i = 0; i < 20; i++) begin
            if (outst == 3) break;
            step();
        end
        chk("inflight3", 64'(outst), 64'd3);
        in_q.delete();
        rst_s = 1;
        step();
        rst_s = 0;
        step();
        chk_reset_state();
        bv = rnd_val();
        cfg(CH, bv);
        for (int i = 0; i < 6; i++) in_q.push_back(rnd_px());
        drain();
        chk("bias_only", 64'(last_wdata), 64'(bv));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
